// File: rtl/calc_entry_ctrl.sv
// Keypad entry sequencer: collects A, operator and B, issues one ALU request and latches the result.
// Optional build macro CALC_CHAIN_EN: an operator key in SHOW chains on the previous result.
module calc_entry_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int MIN_WAIT       = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       alu_done,
    input  logic [7:0] alu_result,
    output logic [3:0] first_nr,
    output logic [3:0] second_nr,
    output logic [3:0] operation,
    output logic       alu_sel,
    output logic       wr_enable,
    output logic [7:0] result_out,
    output logic       result_valid,
    output logic       busy,
    output logic       err
);
    localparam int               CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] MIN_WAIT_C = CNT_W'(MIN_WAIT);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_GOT_A, S_GOT_OP, S_GOT_B, S_ISSUE, S_WAIT, S_SHOW, S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       first_nr_q, first_nr_d;
    logic [3:0]       second_nr_q, second_nr_d;
    logic [3:0]       operation_q, operation_d;
    logic             alu_sel_q, alu_sel_d;
    logic             wr_enable_q, wr_enable_d;
    logic [7:0]       result_out_q, result_out_d;
    logic             result_valid_q, result_valid_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic key_digit, key_op, key_eq, key_clr, div_by_zero;

    function automatic logic [3:0] op_encode(input logic [3:0] code);
        case (code)
            4'hA:    return 4'b0001;
            4'hB:    return 4'b0010;
            4'hC:    return 4'b0100;
            default: return 4'b0000;
        endcase
    endfunction

    assign key_digit   = key_valid && (key_code <= 4'd9);
    assign key_op      = key_valid && (key_code inside {4'hA, 4'hB, 4'hC});
    assign key_eq      = key_valid && (key_code == 4'hE);
    assign key_clr     = key_valid && (key_code == 4'hD);
    assign div_by_zero = (operation_q == 4'b0100) && (second_nr_q == 4'd0);

    always_comb begin
        state_d        = state_q;
        first_nr_d     = first_nr_q;
        second_nr_d    = second_nr_q;
        operation_d    = operation_q;
        alu_sel_d      = alu_sel_q;
        wr_enable_d    = 1'b0;
        result_out_d   = result_out_q;
        result_valid_d = result_valid_q;
        busy_d         = busy_q;
        err_d          = err_q;
        cnt_d          = cnt_q;

        // Clear wins over everything and drops an in-flight request; the last result stays visible.
        if (key_clr) begin
            state_d        = S_IDLE;
            first_nr_d     = 4'd0;
            second_nr_d    = 4'd0;
            operation_d    = 4'd0;
            alu_sel_d      = 1'b0;
            result_valid_d = 1'b0;
            busy_d         = 1'b0;
            err_d          = 1'b0;
            cnt_d          = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (key_digit) begin
                        first_nr_d = key_code;
                        state_d    = S_GOT_A;
                    end
                end
                S_GOT_A: begin
                    if (key_digit) begin
                        first_nr_d = key_code;
                    end else if (key_op) begin
                        operation_d = op_encode(key_code);
                        state_d     = S_GOT_OP;
                    end
                end
                S_GOT_OP: begin
                    if (key_op) begin
                        operation_d = op_encode(key_code);
                    end else if (key_digit) begin
                        second_nr_d = key_code;
                        state_d     = S_GOT_B;
                    end
                end
                S_GOT_B: begin
                    if (key_digit) begin
                        second_nr_d = key_code;
                    end else if (key_eq) begin
                        result_valid_d = 1'b0;
                        if (div_by_zero) begin
                            err_d   = 1'b1;
                            state_d = S_ERR;
                        end else begin
                            wr_enable_d = 1'b1;
                            alu_sel_d   = 1'b1;
                            busy_d      = 1'b1;
                            state_d     = S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    // The first MIN_WAIT cycles mask a done level left over from the previous request.
                    if (alu_done && (cnt_q >= MIN_WAIT_C)) begin
                        result_out_d   = alu_result;
                        result_valid_d = 1'b1;
                        alu_sel_d      = 1'b0;
                        busy_d         = 1'b0;
                        cnt_d          = '0;
                        state_d        = S_SHOW;
                    end else if (cnt_q == CNT_LAST) begin
                        err_d          = 1'b1;
                        result_valid_d = 1'b0;
                        alu_sel_d      = 1'b0;
                        busy_d         = 1'b0;
                        cnt_d          = '0;
                        state_d        = S_ERR;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_SHOW: begin
                    if (key_digit) begin
                        first_nr_d     = key_code;
                        result_valid_d = 1'b0;
                        state_d        = S_GOT_A;
                    end
`ifdef CALC_CHAIN_EN
                    else if (key_op) begin
                        result_valid_d = 1'b0;
                        if (result_out_q <= 8'd15) begin
                            first_nr_d  = result_out_q[3:0];
                            operation_d = op_encode(key_code);
                            state_d     = S_GOT_OP;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_ERR;
                        end
                    end
`endif
                end
                S_ERR: begin
                    state_d = S_ERR;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            first_nr_q     <= 4'd0;
            second_nr_q    <= 4'd0;
            operation_q    <= 4'd0;
            alu_sel_q      <= 1'b0;
            wr_enable_q    <= 1'b0;
            result_out_q   <= 8'd0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            err_q          <= 1'b0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            first_nr_q     <= first_nr_d;
            second_nr_q    <= second_nr_d;
            operation_q    <= operation_d;
            alu_sel_q      <= alu_sel_d;
            wr_enable_q    <= wr_enable_d;
            result_out_q   <= result_out_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
            err_q          <= err_d;
            cnt_q          <= cnt_d;
        end
    end

    assign first_nr     = first_nr_q;
    assign second_nr    = second_nr_q;
    assign operation    = operation_q;
    assign alu_sel      = alu_sel_q;
    assign wr_enable    = wr_enable_q;
    assign result_out   = result_out_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;
    assign err          = err_q;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Bench for calc_entry_ctrl: directed key sequences plus random keys, checked every cycle
// against a field-collection reference model (honours CALC_CHAIN_EN when defined).
module tb_calc_entry_ctrl;
    localparam int TIMEOUT_CYCLES = 64;
    localparam int MIN_WAIT       = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       alu_done = 1'b0;
    logic [7:0] alu_result = 8'h00;
    logic [3:0] first_nr, second_nr, operation;
    logic       alu_sel, wr_enable, result_valid, busy, err;
    logic [7:0] result_out;

    int n_chk  = 0;
    int n_fail = 0;
    int wr_cnt = 0;

    bit         done_lvl = 1'b0;
    logic [7:0] res_lvl  = 8'h00;

    // Reference model: which entry fields are filled, where a request is, and the visible values.
    logic [3:0] m_a, m_b, m_op;
    logic [7:0] m_res;
    bit         m_rv, m_err, m_wr, m_show;
    int         m_fields;  // 0 none, 1 A, 2 A+op, 3 A+op+B
    int         m_req;     // 0 none, 1 write cycle, 2 waiting for done
    int         m_waited;

    calc_entry_ctrl #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .MIN_WAIT      (MIN_WAIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .alu_done    (alu_done),
        .alu_result  (alu_result),
        .first_nr    (first_nr),
        .second_nr   (second_nr),
        .operation   (operation),
        .alu_sel     (alu_sel),
        .wr_enable   (wr_enable),
        .result_out  (result_out),
        .result_valid(result_valid),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_outs();
        return {7'd0, first_nr, second_nr, operation, alu_sel, wr_enable,
                result_out, result_valid, busy, err};
    endfunction

    function automatic logic [31:0] model_outs();
        bit inflight;
        inflight = (m_req != 0);
        return {7'd0, m_a, m_b, m_op, inflight, m_wr, m_res, m_rv, inflight, m_err};
    endfunction

    function automatic logic [3:0] op_code(input logic [3:0] k);
        if (k == 4'hA) return 4'b0001;
        if (k == 4'hB) return 4'b0010;
        return 4'b0100;
    endfunction

    task automatic model_reset();
        m_a = 0; m_b = 0; m_op = 0; m_res = 0;
        m_rv = 0; m_err = 0; m_wr = 0; m_show = 0;
        m_fields = 0; m_req = 0; m_waited = 0;
    endtask

    task automatic model_edge(input bit kv, input logic [3:0] kc);
        bit dig, opk, eq, clr;
        dig = kv && (kc <= 4'd9);
        opk = kv && (kc >= 4'hA) && (kc <= 4'hC);
        eq  = kv && (kc == 4'hE);
        clr = kv && (kc == 4'hD);
        m_wr = 0;
        if (clr) begin
            m_a = 0; m_b = 0; m_op = 0; m_rv = 0; m_err = 0;
            m_show = 0; m_fields = 0; m_req = 0; m_waited = 0;
        end else if (m_err) begin
            // only clear leaves the error
        end else if (m_req == 1) begin
            m_req = 2; m_waited = 0;
        end else if (m_req == 2) begin
            if (done_lvl && m_waited >= MIN_WAIT) begin
                m_res = res_lvl; m_rv = 1; m_req = 0; m_show = 1;
            end else if (m_waited + 1 >= TIMEOUT_CYCLES) begin
                m_req = 0; m_err = 1; m_rv = 0;
            end else begin
                m_waited++;
            end
        end else if (m_show) begin
            if (dig) begin
                m_a = kc; m_rv = 0; m_show = 0; m_fields = 1;
            end
`ifdef CALC_CHAIN_EN
            else if (opk) begin
                m_show = 0; m_rv = 0;
                if (m_res <= 15) begin
                    m_a = m_res[3:0]; m_op = op_code(kc); m_fields = 2;
                end else begin
                    m_err = 1;
                end
            end
`endif
        end else begin
            case (m_fields)
                0: if (dig) begin m_a = kc; m_fields = 1; end
                1: if (dig) m_a = kc;
                   else if (opk) begin m_op = op_code(kc); m_fields = 2; end
                2: if (opk) m_op = op_code(kc);
                   else if (dig) begin m_b = kc; m_fields = 3; end
                default: if (dig) m_b = kc;
                   else if (eq) begin
                       m_rv = 0; m_fields = 0;
                       if (m_op == 4'b0100 && m_b == 0) m_err = 1;
                       else begin m_req = 1; m_wr = 1; end
                   end
            endcase
        end
    endtask

    task automatic step(input bit kv, input logic [3:0] kc);
        @(negedge clk);
        key_valid  = kv;
        key_code   = kc;
        alu_done   = done_lvl;
        alu_result = res_lvl;
        @(posedge clk);
        model_edge(kv, kc);
        #1;
        if (wr_enable) wr_cnt++;
        check_eq("outs", dut_outs(), model_outs());
    endtask

    task automatic key(input logic [3:0] kc);
        step(1'b1, kc);
    endtask

    task automatic idle();
        step(1'b0, 4'h0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; key_valid = 0; key_code = 0; alu_done = 0; alu_result = 0;
        #1;
        model_reset();
        check_eq("reset", dut_outs(), model_outs());
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [3:0] rand_key();
        int r;
        r = $urandom_range(0, 99);
        if (r < 55) return 4'($urandom_range(0, 9));
        if (r < 77) return 4'($urandom_range(10, 12));
        if (r < 90) return 4'hE;
        if (r < 97) return 4'hF;
        return 4'hD;
    endfunction

    initial begin
        int done_pct;
        apply_reset();

        // Basic add with done after three wait cycles
        wr_cnt = 0;
        key(4'h3); key(4'hA); key(4'h4); key(4'hE);
        check_eq("t1_ops", {20'd0, first_nr, second_nr, operation}, {20'd0, 4'd3, 4'd4, 4'b0001});
        check_eq("t1_wr", {31'd0, wr_enable}, 32'd1);
        idle(); idle(); idle();
        done_lvl = 1; res_lvl = 8'h07;
        idle();
        check_eq("t1_res", {24'd0, result_out}, 32'h07);
        check_eq("t1_flags", {29'd0, result_valid, alu_sel, busy}, {29'd0, 3'b100});
        check_eq("t1_wr_cnt", wr_cnt, 1);

        // Stale done level is masked for MIN_WAIT cycles
        res_lvl = 8'h33;
        key(4'h2); key(4'hA); key(4'h5); key(4'hE);
        idle(); idle(); idle();
        check_eq("mask_hold", {24'd0, result_out}, 32'h07);
        idle();
        check_eq("mask_upd", {24'd0, result_out}, 32'h33);
        check_eq("mask_rv", {31'd0, result_valid}, 32'd1);

        // Divide by zero goes straight to error without a request
        done_lvl = 0;
        key(4'hD);
        wr_cnt = 0;
        key(4'h7); key(4'hC); key(4'h0); key(4'hE);
        check_eq("dz_err", {31'd0, err}, 32'd1);
        idle(); idle();
        check_eq("dz_wr_cnt", wr_cnt, 0);
        key(4'hD);
        check_eq("dz_clr", {31'd0, err}, 32'd0);

        // Timeout with done held low
        key(4'h9); key(4'hB); key(4'h9); key(4'hE);
        idle();
        repeat (TIMEOUT_CYCLES - 1) idle();
        check_eq("tmo_pre", {30'd0, err, busy}, {30'd0, 2'b01});
        idle();
        check_eq("tmo_err", {30'd0, err, alu_sel}, {30'd0, 2'b10});
        key(4'hD);

        // Overwrites, then clear while waiting
        key(4'h5); key(4'h6); key(4'hA); key(4'hB); key(4'h8); key(4'h2); key(4'hE);
        check_eq("ow_ops", {20'd0, first_nr, second_nr, operation}, {20'd0, 4'd6, 4'd2, 4'b0010});
        idle(); idle();
        key(4'hD);
        check_eq("clr_sel", {31'd0, alu_sel}, 32'd0);
        done_lvl = 1; res_lvl = 8'h55;
        idle(); idle(); idle();
        check_eq("clr_rv", {31'd0, result_valid}, 32'd0);
        check_eq("clr_hold", {24'd0, result_out}, 32'h33);
        done_lvl = 0;

        // Chaining on a small result, then on one too large
        key(4'h3); key(4'hB); key(4'h4); key(4'hE);
        idle(); idle(); idle();
        done_lvl = 1; res_lvl = 8'h0C;
        idle();
        done_lvl = 0;
        key(4'hA); key(4'h2); key(4'hE);
`ifdef CALC_CHAIN_EN
        check_eq("chain_ops", {20'd0, first_nr, second_nr, operation}, {20'd0, 4'hC, 4'd2, 4'b0001});
`endif
        idle(); idle(); idle();
        done_lvl = 1; res_lvl = 8'h14;
        idle();
        done_lvl = 0;
        key(4'hB);
`ifdef CALC_CHAIN_EN
        check_eq("chain_err", {31'd0, err}, 32'd1);
`endif
        key(4'hD);

        // Asynchronous reset in the middle of a request
        key(4'h1); key(4'hA); key(4'h1); key(4'hE); idle();
        apply_reset();

        // Random keys with varying ALU behaviour
        done_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) begin
                case ($urandom_range(0, 3))
                    0:       done_pct = 0;
                    1:       done_pct = 15;
                    2:       done_pct = 50;
                    default: done_pct = 100;
                endcase
            end
            done_lvl = ($urandom_range(0, 99) < done_pct);
            res_lvl  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 20)) : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 99) < 50) step(1'b1, rand_key());
            else step(1'b0, 4'($urandom_range(0, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
